// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port, 1-cycle-latency data RAM (read, word write, byte-lane RMW).
// Optional macro DMEM_ARB_RR_EN: round-robin on contention; otherwise port A has fixed priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RAM_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [31:0]       a_wdata_i,
  input  logic [3:0]        a_be_i,
  output logic              a_gnt_o,
  output logic              a_done_o,
  output logic [31:0]       a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [31:0]       b_wdata_i,
  input  logic [3:0]        b_be_i,
  output logic              b_gnt_o,
  output logic              b_done_o,
  output logic [31:0]       b_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [RAM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i,
  output logic              busy_o
);
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_RSP, S_WR, S_RMW_RD, S_RMW_WR
  } state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [BEW-1:0]    be_q, be_d;
  logic              owner_q, owner_d;  // 0 = port A, 1 = port B
  logic              prio_a;
  logic              gnt_a, gnt_b;
  logic [DW-1:0]     merged;

  // Only the word-address bits select a RAM row
  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr_i[ADDR_W-1:RAM_AW+2], a_addr_i[1:0],
                              b_addr_i[ADDR_W-1:RAM_AW+2], b_addr_i[1:0]};

`ifdef DMEM_ARB_RR_EN
  logic last_b_q, last_b_d;
  assign prio_a = last_b_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_b_q <= 1'b1;
    else          last_b_q <= last_b_d;
  end
`else
  assign prio_a = 1'b1;
`endif

  // State and latched-request registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    for (int n = 0; n < int'(BEW); n++) begin
      merged[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : ram_rdata_i[8*n +: 8];
    end
  end

  // Next state, request latch and output decode
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    owner_d     = owner_q;
`ifdef DMEM_ARB_RR_EN
    last_b_d    = last_b_q;
`endif
    gnt_a       = 1'b0;
    gnt_b       = 1'b0;
    a_gnt_o     = 1'b0;
    b_gnt_o     = 1'b0;
    a_done_o    = 1'b0;
    b_done_o    = 1'b0;
    a_rdata_o   = '0;
    b_rdata_o   = '0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    busy_o      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        gnt_a   = rst_n_i & a_req_i & (~b_req_i | prio_a);
        gnt_b   = rst_n_i & b_req_i & ~gnt_a;
        a_gnt_o = gnt_a;
        b_gnt_o = gnt_b;
        if (gnt_a || gnt_b) begin
          we_d    = gnt_a ? a_we_i : b_we_i;
          addr_d  = gnt_a ? a_addr_i[RAM_AW+1:2] : b_addr_i[RAM_AW+1:2];
          wdata_d = gnt_a ? a_wdata_i : b_wdata_i;
          be_d    = gnt_a ? a_be_i : b_be_i;
          owner_d = gnt_b;
`ifdef DMEM_ARB_RR_EN
          last_b_d = gnt_b;
`endif
          if (!we_d)                                   state_d = S_RD;
          else if (be_d == '1 || be_d == BEW'(0))      state_d = S_WR;
          else                                         state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        ram_en_o   = 1'b1;
        ram_addr_o = addr_q;
        state_d    = S_RD_RSP;
      end
      S_RD_RSP: begin
        a_done_o  = ~owner_q;
        b_done_o  = owner_q;
        a_rdata_o = owner_q ? '0 : ram_rdata_i;
        b_rdata_o = owner_q ? ram_rdata_i : '0;
        state_d   = S_IDLE;
      end
      S_WR: begin
        // An all-zero lane mask completes without touching the RAM
        if (be_q != BEW'(0)) begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = addr_q;
          ram_wdata_o = wdata_q;
        end
        a_done_o = ~owner_q;
        b_done_o = owner_q;
        state_d  = S_IDLE;
      end
      S_RMW_RD: begin
        ram_en_o   = 1'b1;
        ram_addr_o = addr_q;
        state_d    = S_RMW_WR;
      end
      S_RMW_WR: begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = addr_q;
        ram_wdata_o = merged;
        a_done_o    = ~owner_q;
        b_done_o    = owner_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_be, b_be;
  logic        a_gnt, a_done, b_gnt, b_done;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_en, ram_we, busy;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .RAM_AW(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_be_i(a_be),
    .a_gnt_o(a_gnt), .a_done_o(a_done), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_be_i(b_be),
    .b_gnt_o(b_gnt), .b_done_o(b_done), .b_rdata_o(b_rdata),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .busy_o(busy)
  );

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk); @(negedge clk); #1;
  endtask

  task automatic preload(input logic [11:0] wa, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = wa; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic drive_a(input logic we, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = d; a_be = be;
  endtask

  task automatic drive_b(input logic we, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] be);
    b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = d; b_be = be;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_req = 1'b1; a_we = 1'b0; a_addr = 32'h1000;
    step();
    n_cmp++; if (a_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %0b want 0", a_gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== 46'd0) begin n_fail++; $display("FAIL rst_ram: got en=%0b we=%0b addr=%h wd=%h want 0", ram_en, ram_we, ram_addr, ram_wdata); end
    n_cmp++; if ({a_done, b_done, a_rdata, b_rdata} !== 66'd0) begin n_fail++; $display("FAIL rst_done: got %0b/%0b want 0", a_done, b_done); end
    a_req = 1'b0; rst_n = 1'b1;
    step();
  endtask

  task automatic test_full_write();
    drive_a(1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111); #1;
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %0b want 1", a_gnt); end
    step(); a_req = 1'b0;
    n_cmp++; if ({ram_en, ram_we} !== 2'b11) begin n_fail++; $display("FAIL wr_en_we: got %b want 11", {ram_en, ram_we}); end
    n_cmp++; if (ram_addr !== 12'h400 || ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_addr_data: got %h/%h want 400/deadbeef", ram_addr, ram_wdata); end
    n_cmp++; if (a_done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL wr_done: got done=%0b busy=%0b want 1/1", a_done, busy); end
    step();
    n_cmp++; if (busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got busy=%0b done=%0b want 0/0", busy, a_done); end
    n_cmp++; if (mem[12'h400] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem: got %h want deadbeef", mem[12'h400]); end
  endtask

  task automatic test_read();
    drive_a(1'b0, 32'h1000, 32'h0, 4'b0000); #1;
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %0b want 1", a_gnt); end
    step(); a_req = 1'b0;
    n_cmp++; if ({ram_en, ram_we, a_done} !== 3'b100 || ram_addr !== 12'h400) begin n_fail++; $display("FAIL rd_issue: got en/we/done=%b addr=%h want 100/400", {ram_en, ram_we, a_done}, ram_addr); end
    step();
    n_cmp++; if (a_done !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp: got done=%0b rdata=%h want 1/deadbeef", a_done, a_rdata); end
    n_cmp++; if (b_done !== 1'b0 || b_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_b_quiet: got %0b/%h want 0/0", b_done, b_rdata); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got %0b want 0", busy); end
  endtask

  task automatic test_rmw();
    preload(12'h401, 32'h11223344);
    drive_a(1'b1, 32'h1004, 32'h0000AB00, 4'b0010); #1;
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rmw_gnt: got %0b want 1", a_gnt); end
    step(); a_req = 1'b0;
    n_cmp++; if ({ram_en, ram_we, a_done} !== 3'b100) begin n_fail++; $display("FAIL rmw_rd: got en/we/done=%b want 100", {ram_en, ram_we, a_done}); end
    step();
    n_cmp++; if ({ram_en, ram_we} !== 2'b11 || ram_wdata !== 32'h1122AB44) begin n_fail++; $display("FAIL rmw_wr: got en/we=%b wd=%h want 11/1122ab44", {ram_en, ram_we}, ram_wdata); end
    n_cmp++; if (a_done !== 1'b1 || b_done !== 1'b0) begin n_fail++; $display("FAIL rmw_done: got a=%0b b=%0b want 1/0", a_done, b_done); end
    step();
    n_cmp++; if (mem[12'h401] !== 32'h1122AB44) begin n_fail++; $display("FAIL rmw_mem: got %h want 1122ab44", mem[12'h401]); end
  endtask

  task automatic test_zero_be();
    preload(12'h402, 32'h55AA55AA);
    drive_a(1'b1, 32'h1008, 32'hFFFFFFFF, 4'b0000); #1;
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL be0_gnt: got %0b want 1", a_gnt); end
    step(); a_req = 1'b0;
    n_cmp++; if (ram_en !== 1'b0 || a_done !== 1'b1) begin n_fail++; $display("FAIL be0_t1: got en=%0b done=%0b want 0/1", ram_en, a_done); end
    step();
    n_cmp++; if (mem[12'h402] !== 32'h55AA55AA || busy !== 1'b0) begin n_fail++; $display("FAIL be0_mem: got %h busy=%0b want 55aa55aa/0", mem[12'h402], busy); end
  endtask

  task automatic test_contention();
    logic exp_a;
    drive_a(1'b0, 32'h1000, 32'h0, 4'b0000);
    drive_b(1'b0, 32'h1004, 32'h0, 4'b0000); #1;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_a = (i % 2 == 0);
`else
      exp_a = 1'b1;
`endif
      n_cmp++; if ({a_gnt, b_gnt} !== {exp_a, ~exp_a}) begin n_fail++; $display("FAIL arb_gnt%0d: got a=%0b b=%0b want %0b/%0b", i, a_gnt, b_gnt, exp_a, ~exp_a); end
      step(); step();
      if (exp_a) begin
        n_cmp++; if (a_done !== 1'b1 || a_rdata !== 32'hDEADBEEF || b_done !== 1'b0) begin n_fail++; $display("FAIL arb_rsp%0d: got a=%0b %h b=%0b want 1 deadbeef 0", i, a_done, a_rdata, b_done); end
      end else begin
        n_cmp++; if (b_done !== 1'b1 || b_rdata !== 32'h1122AB44 || a_done !== 1'b0) begin n_fail++; $display("FAIL arb_rsp%0d: got b=%0b %h a=%0b want 1 1122ab44 0", i, b_done, b_rdata, a_done); end
      end
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    drive_a(1'b1, 32'h1004, 32'h000000FF, 4'b0001); #1;
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL rstm_gnt: got %0b want 1", a_gnt); end
    step();
    n_cmp++; if ({ram_en, ram_we, busy} !== 3'b101) begin n_fail++; $display("FAIL rstm_rmw_rd: got %b want 101", {ram_en, ram_we, busy}); end
    rst_n = 1'b0; #1;
    n_cmp++; if ({ram_en, ram_we, busy, a_gnt, a_done} !== 5'b0 || ram_addr !== 12'h0 || ram_wdata !== 32'h0) begin n_fail++; $display("FAIL rstm_outs: got en/we/busy/gnt/done=%b addr=%h wd=%h want 0", {ram_en, ram_we, busy, a_gnt, a_done}, ram_addr, ram_wdata); end
    a_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (mem[12'h401] !== 32'h1122AB44) begin n_fail++; $display("FAIL rstm_mem: got %h want 1122ab44", mem[12'h401]); end
    drive_b(1'b0, 32'h1004, 32'h0, 4'b0000); #1;
    n_cmp++; if (b_gnt !== 1'b1) begin n_fail++; $display("FAIL rstm_regnt: got %0b want 1", b_gnt); end
    step(); b_req = 1'b0;
    step();
    n_cmp++; if (b_done !== 1'b1 || b_rdata !== 32'h1122AB44) begin n_fail++; $display("FAIL rstm_rd: got %0b %h want 1 1122ab44", b_done, b_rdata); end
    step();
  endtask

  task automatic test_b_during_a();
    drive_a(1'b0, 32'h1000, 32'h0, 4'b0000); #1;
    n_cmp++; if (a_gnt !== 1'b1) begin n_fail++; $display("FAIL bda_agnt: got %0b want 1", a_gnt); end
    step(); a_req = 1'b0;
    drive_b(1'b0, 32'h1004, 32'h0, 4'b0000); #1;
    n_cmp++; if (b_gnt !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bda_t1: got gnt=%0b busy=%0b want 0/1", b_gnt, busy); end
    step();
    n_cmp++; if (a_done !== 1'b1 || b_gnt !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bda_t2: got done=%0b gnt=%0b busy=%0b want 1/0/1", a_done, b_gnt, busy); end
    step();
    n_cmp++; if (b_gnt !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bda_t3: got gnt=%0b busy=%0b want 1/0", b_gnt, busy); end
    step(); b_req = 1'b0;
    step();
    n_cmp++; if (b_done !== 1'b1 || b_rdata !== 32'h1122AB44 || a_done !== 1'b0) begin n_fail++; $display("FAIL bda_rsp: got b=%0b %h a=%0b want 1 1122ab44 0", b_done, b_rdata, a_done); end
    step();
  endtask

  initial begin
    rst_n = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    @(negedge clk); #1;
    test_reset();
    test_full_write();
    test_read();
    test_rmw();
    test_zero_be();
    test_reset();
    test_contention();
    test_reset_mid();
    test_b_during_a();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
